// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg: shared types for the parallel-to-serial front end
package piso_serializer_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} ser_state_e;
endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: accepts a word over valid/ready and streams it bit-serially into a downstream shift register
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             dir_i,
  output logic             ser_en_o,
  output logic             ser_dir_o,
  output logic             ser_data_o,
  output logic             busy_o,
  output logic             done_o
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP > 0 ? GAP - 1 : 0);
  ser_state_e state_q;
  logic [WIDTH-1:0] word_q;
  logic dir_q;
  logic [CW-1:0] bit_cnt, nxt_cnt, rev_cnt;
  logic [7:0] gap_cnt;
  assign nxt_cnt = bit_cnt + 1'b1;
  assign rev_cnt = LAST - nxt_cnt;
  assign ser_dir_o = dir_q;
  // outputs are loaded one edge ahead, so ser_data_o always shows the bit for bit_cnt
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      word_q     <= '0;
      dir_q      <= 1'b0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      ready_o    <= 1'b1;
      busy_o     <= 1'b0;
      ser_en_o   <= 1'b0;
      ser_data_o <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: if (valid_i && ready_o) begin
          word_q     <= data_i;
          dir_q      <= dir_i;
          bit_cnt    <= '0;
          ready_o    <= 1'b0;
          busy_o     <= 1'b1;
          ser_en_o   <= 1'b1;
          ser_data_o <= dir_i ? data_i[0] : data_i[WIDTH-1];
          state_q    <= SHIFT;
        end
        SHIFT: if (bit_cnt == LAST) begin
          ser_en_o   <= 1'b0;
          ser_data_o <= 1'b0;
          done_o     <= 1'b1;
          gap_cnt    <= '0;
          ready_o    <= (GAP == 0);
          busy_o     <= (GAP != 0);
          state_q    <= (GAP > 0) ? piso_serializer_pkg::GAP : IDLE;
        end else begin
          bit_cnt    <= nxt_cnt;
          ser_data_o <= word_q[dir_q ? nxt_cnt : rev_cnt];
        end
        piso_serializer_pkg::GAP: if (gap_cnt == GAP_LAST) begin
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out front end for the serial datapath. Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per cycle as `ser_data_o`/`ser_en_o`/`ser_dir_o`. These drive the `data_i`/`en_i`/`dir_i` inputs of the downstream `shift_register`. Bit order follows the chosen direction, so after WIDTH enabled cycles the downstream register holds the original word, and `done_o` marks that cycle.

## Interface
- `WIDTH`, default 8: word width; must be ≥ 2 and equal the downstream register width.
- `GAP`, default 0: number of forced idle cycles after each word (0..255).
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rstn_i`  in  1  reset; asynchronous, active-low.
- `valid_i`  in  1  upstream word valid.
- `ready_o`  out  1  block can accept a word.
- `data_i`  in  WIDTH  word to serialize.
- `dir_i`  in  1  direction, sampled with the word: 0 = downstream shifts left (send MSB first); 1 = downstream shifts right (send LSB first).
- `ser_en_o`  out  1  shift enable to downstream.
- `ser_dir_o`  out  1  direction to downstream, held for the whole word.
- `ser_data_o`  out  1  serial bit.
- `busy_o`  out  1  high in SHIFT or GAP.
- `done_o`  out  1  one-cycle pulse: the downstream register now holds the complete word.

## Operation
- FSM states: IDLE, SHIFT, GAP.
- **IDLE:**
  - `ready_o` = 1.
  - On `valid_i && ready_o`: latch `data_i` into `word_q` and `dir_i` into `dir_q`, clear `bit_cnt`, go to SHIFT.
- **SHIFT:**
  - `ser_en_o` = 1.
  - `ser_data_o` = `word_q[WIDTH-1-bit_cnt]` when `dir_q` = 0, else `word_q[bit_cnt]`.
  - `bit_cnt` increments each cycle.
  - When `bit_cnt` == WIDTH-1, go to GAP if GAP > 0, else IDLE.
- **GAP:**
  - Count GAP cycles with `ready_o` = 0, then go to IDLE.
- **Output defaults:**
  - `ser_en_o`, `ser_data_o` and `done_o` are 0 whenever not asserted as above.
  - `ser_dir_o` = `dir_q` at all times; it changes only on acceptance.
- `done_o` is asserted for exactly one cycle: the first cycle after the last SHIFT cycle.
- Input changes on `valid_i`/`data_i`/`dir_i` outside the acceptance cycle have no effect.
- `bit_cnt` is `$clog2(WIDTH)` bits wide; no wrap beyond WIDTH-1 is permitted.
- The GAP counter is 8 bits.

## Timing
- All outputs are registered.
- Reset values:
  - `ready_o` = 1; `ser_en_o`, `ser_dir_o`, `ser_data_o`, `busy_o`, `done_o` = 0.
  - State = IDLE; `word_q`, `dir_q` and all counters = 0.
- Cycle sequence for a word accepted on edge t:
  - Cycles t+1 .. t+WIDTH: `ser_en_o` = 1, one bit per cycle.
  - Cycle t+WIDTH+1: `done_o` = 1.
- `ready_o` falls on cycle t+1 and rises again on cycle t+WIDTH+1+GAP.
- With GAP = 0, a word may be accepted in the `done_o` cycle. The next word's first bit then appears one cycle after `done_o`, giving a minimum of one idle serial cycle between words.
- `busy_o` = !`ready_o`.
- Reset mid-word: all outputs return to their reset values immediately (asynchronous), the partial word is discarded, and no `done_o` is produced.

## Structure
- Package `piso_serializer_pkg` holds the state enum `ser_state_e` {IDLE, SHIFT, GAP}.
- Single module; no sub-module needed.
- The testbench instantiates the downstream `shift_register` with MSB = WIDTH as the scoreboard sink.

## Test plan
- Reset released, `valid_i` = 0 → `ready_o` = 1, all other outputs 0, no `ser_en_o` pulses.
- WIDTH = 8, `data_i` = 0xB4, `dir_i` = 0 → `ser_data_o` = 1,0,1,1,0,1,0,0 over 8 enabled cycles; at `done_o`, the downstream `data_o` = 0xB4.
- `data_i` = 0xB4, `dir_i` = 1 → `ser_data_o` = 0,0,1,0,1,1,0,1; `ser_dir_o` = 1 throughout; the downstream `data_o` = 0xB4 at `done_o`.
- GAP = 0, `valid_i` held high with 0x12 then 0x34 → second acceptance in the `done_o` cycle; exactly one cycle with `ser_en_o` = 0 between the words; the downstream register shows 0x12 then 0x34.
- GAP = 3 → `ready_o` = 0 for the 3 cycles after `done_o`, and `valid_i` is ignored there.
- `rstn_i` asserted after the 4th bit of 0xFF → outputs go to 0 immediately, no `done_o`; the next word 0x0F completes correctly.
